// File: rtl/bit_serial_alu_seq_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// The caller (master) presents operands and an op code with start,
// then waits for the one-cycle done pulse. Result and flags are held
// until the next accepted request completes.
interface bit_serial_alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       cntrl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output start, A, B, cntrl,
        input  busy, done, result, negative, zero, overflow, carry_out
    );

    modport slave (
        input  start, A, B, cntrl,
        output busy, done, result, negative, zero, overflow, carry_out
    );
endinterface

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: runs a 1-bit ALU slice once per clock, LSB
// first, keeping the carry in a flop between bits. Slice results are
// shifted into the MSB of a shift register. The visible result and flags
// only change on the edge that finishes the last bit, so a running
// operation never disturbs the previous op's outputs.
// Ops: 000=B, 010=A+B, 011=A-B, 100=A&B, 101=A|B, 110=A^B, 001/111 -> 0.
// A request accepted on edge 0 processes bit i on edge i+1, so done is
// visible after the WIDTH+1'th edge counting the accepting edge.
module bit_serial_alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic clk,
    input  logic reset,
    bit_serial_alu_seq_if.slave bus
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Holds the WIDTH-1 bits already processed; the last bit goes
    // straight into the result, so a WIDTH-1 bit register is enough.
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             negative_q, negative_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             carry_out_q, carry_out_d;

    logic             a_bit, b_bit, b_eff;
    logic             sum_bit, cout_bit, res_bit;
    logic             is_arith;
    logic [WIDTH-1:0] full_word;

    // One-bit ALU slice on the current LSBs of the operand shifters.
    always_comb begin
        a_bit    = a_q[0];
        b_bit    = b_q[0];
        b_eff    = b_bit ^ op_q[0];
        sum_bit  = a_bit ^ b_eff ^ carry_q;
        cout_bit = (a_bit & b_eff) | (b_eff & carry_q) | (a_bit & carry_q);
        is_arith = (op_q[2:1] == 2'b01);
        case (op_q)
            3'b000:  res_bit = b_bit;
            3'b010,
            3'b011:  res_bit = sum_bit;
            3'b100:  res_bit = a_bit & b_bit;
            3'b101:  res_bit = a_bit | b_bit;
            3'b110:  res_bit = a_bit ^ b_bit;
            default: res_bit = 1'b0;
        endcase
        // New bit enters at the MSB; on the last bit this is the full result.
        full_word = {res_bit, sr_q};
    end

    // Sequencer next-state, operand shifting and result/flag capture.
    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a variable
        // unassigned -- that is what keeps this block free of latches.
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        sr_d        = sr_q;
        result_d    = result_q;
        negative_d  = negative_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        carry_out_d = carry_out_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = bus.cntrl;
                    idx_d   = '0;
                    carry_d = (bus.cntrl == 3'b011);
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sr_d    = full_word[WIDTH-1:1];
                carry_d = cout_bit;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    result_d    = full_word;
                    negative_d  = full_word[WIDTH-1];
                    zero_d      = (full_word == '0);
                    // carry_q here is the carry into the MSB.
                    overflow_d  = is_arith & (carry_q ^ cout_bit);
                    carry_out_d = is_arith & cout_bit;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation and clears all outputs.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: flops use non-blocking assignments so every register
        // samples the pre-edge values of its neighbours.
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sr_q        <= '0;
            result_q    <= '0;
            negative_q  <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sr_q        <= sr_d;
            result_q    <= result_d;
            negative_q  <= negative_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.negative  = negative_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.carry_out = carry_out_q;

endmodule
